// File: rtl/psrx_pkg.sv
// Shared definitions for the serial receive synchronisation path.
package psrx_pkg;

  localparam int          BYTE_W     = 8;
  localparam logic [7:0]  COMMA_BYTE = 8'hBC;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

endpackage

// File: rtl/psrx_shifter.sv
// Serial-in shift register with a modulo-8 bit counter.
// o_shift_nxt is the byte window including the bit sampled on this edge;
// o_bit_last flags that this edge completes a byte in the current phase.
module psrx_shifter
  import psrx_pkg::*;
(
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              i_data,
  input  logic              i_realign,
  output logic [BYTE_W-1:0] o_shift_nxt,
  output logic              o_bit_last
);

  logic [BYTE_W-1:0] r_shift;
  logic [2:0]        r_bit_cnt;

  assign o_shift_nxt = {r_shift[BYTE_W-2:0], i_data};
  assign o_bit_last  = (r_bit_cnt == 3'd7);

  // Shift one bit in per edge; realign restarts the byte phase so the next bit is bit 0.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_shift   <= '0;
      r_bit_cnt <= 3'd0;
    end else begin
      r_shift <= o_shift_nxt;
      if (i_realign) r_bit_cnt <= 3'd0;
      else           r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/psrx_sync_ctrl.sv
// Receive synchronisation controller: hunts for the comma byte, requires
// BC_THRESH consecutive aligned commas before declaring the link active,
// then delivers non-comma bytes with a valid flag.
module psrx_sync_ctrl
  import psrx_pkg::*;
#(
  parameter logic [7:0] COMMA     = COMMA_BYTE,
  parameter int         BC_THRESH = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              data_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              active,
  output logic              byte_strobe
);

  localparam logic [3:0] THRESH = 4'(BC_THRESH);

  logic [BYTE_W-1:0] w_shift_nxt;
  logic              w_bit_last;
  logic              w_realign;
  logic              w_is_comma;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_bc_cnt;
  logic [3:0]        w_bc_cnt_nxt;
  logic [BYTE_W-1:0] r_data;
  logic [BYTE_W-1:0] w_data_nxt;
  logic              r_valid;
  logic              w_valid_nxt;
  logic              r_strobe;
  logic              w_strobe_nxt;

  psrx_shifter u_shifter (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .i_data      (data_in),
    .i_realign   (w_realign),
    .o_shift_nxt (w_shift_nxt),
    .o_bit_last  (w_bit_last)
  );

  assign w_is_comma = (w_shift_nxt == COMMA);

  // Next-state, comma counting and output update decisions.
  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_bc_cnt_nxt = r_bc_cnt;
    w_realign    = 1'b0;
    w_strobe_nxt = 1'b0;
    w_data_nxt   = r_data;
    w_valid_nxt  = r_valid;
    case (r_state)
      HUNT: begin
        // Bit-slip search: any bit offset may start a byte.
        if (w_is_comma) begin
          w_realign    = 1'b1;
          w_bc_cnt_nxt = 4'd1;
          w_state_nxt  = (THRESH == 4'd1) ? ACTIVE : ALIGN;
        end
      end
      ALIGN: begin
        if (w_bit_last) begin
          w_strobe_nxt = 1'b1;
          if (w_is_comma) begin
            w_bc_cnt_nxt = r_bc_cnt + 4'd1;
            if (r_bc_cnt + 4'd1 == THRESH) w_state_nxt = ACTIVE;
          end else begin
            // A broken comma run discards alignment; the search resumes on the next edge.
            w_bc_cnt_nxt = 4'd0;
            w_state_nxt  = HUNT;
          end
        end
      end
      ACTIVE: begin
        // bc_cnt is held here; only reset leaves this state.
        if (w_bit_last) begin
          w_strobe_nxt = 1'b1;
          if (w_is_comma) begin
            w_valid_nxt = 1'b0;
          end else begin
            w_data_nxt  = w_shift_nxt;
            w_valid_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt  = HUNT;
        w_bc_cnt_nxt = 4'd0;
        w_valid_nxt  = 1'b0;
      end
    endcase
  end

  // State, comma counter and registered outputs.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_state  <= HUNT;
      r_bc_cnt <= 4'd0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_bc_cnt <= w_bc_cnt_nxt;
      r_data   <= w_data_nxt;
      r_valid  <= w_valid_nxt;
      r_strobe <= w_strobe_nxt;
    end
  end

  assign data_out    = r_data;
  assign valid_out   = r_valid;
  assign active      = (r_state == ACTIVE);
  assign byte_strobe = r_strobe;

endmodule

// File: tb/tb_psrx_sync_ctrl.sv
// Bench for psrx_sync_ctrl: two instances (BC_THRESH 4 and 1) share one
// serial stream and reset; each is compared every cycle against a
// bit-history model of the alignment rules, plus literal spot checks.
module tb_psrx_sync_ctrl;

  localparam logic [7:0] COMMA = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic       data_in = 1'b0;

  logic [7:0] data_out4, data_out1;
  logic       valid_out4, valid_out1;
  logic       active4, active1;
  logic       byte_strobe4, byte_strobe1;

  int n_checks = 0;
  int n_errors = 0;

  psrx_sync_ctrl #(.COMMA(COMMA), .BC_THRESH(4)) dut4 (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (data_in),
    .data_out    (data_out4),
    .valid_out   (valid_out4),
    .active      (active4),
    .byte_strobe (byte_strobe4)
  );

  psrx_sync_ctrl #(.COMMA(COMMA), .BC_THRESH(1)) dut1 (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (data_in),
    .data_out    (data_out1),
    .valid_out   (valid_out1),
    .active      (active1),
    .byte_strobe (byte_strobe1)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (index 0: thresh 4, index 1: thresh 1)
  int         m_thresh [2] = '{4, 1};
  logic [7:0] m_hist   [2];
  bit         m_found  [2];   // a comma has fixed the byte phase
  bit         m_sync   [2];   // link declared up
  int         m_commas [2];
  int         m_since  [2];   // bits received since the phase was fixed
  logic [7:0] m_data   [2];
  bit         m_valid  [2];
  bit         m_strobe [2];

  function automatic void model_clear(input int k);
    m_hist[k]   = 8'h00;
    m_found[k]  = 1'b0;
    m_sync[k]   = 1'b0;
    m_commas[k] = 0;
    m_since[k]  = 0;
    m_data[k]   = 8'h00;
    m_valid[k]  = 1'b0;
    m_strobe[k] = 1'b0;
  endfunction

  function automatic void model_step(input int k, input bit b);
    m_hist[k]   = {m_hist[k][6:0], b};
    m_strobe[k] = 1'b0;
    if (!m_found[k]) begin
      if (m_hist[k] == COMMA) begin
        m_found[k]  = 1'b1;
        m_since[k]  = 0;
        m_commas[k] = 1;
        m_sync[k]   = (m_thresh[k] == 1);
      end
    end else begin
      m_since[k]++;
      if (m_since[k] % 8 == 0) begin
        m_strobe[k] = 1'b1;
        if (m_sync[k]) begin
          if (m_hist[k] == COMMA) m_valid[k] = 1'b0;
          else begin
            m_data[k]  = m_hist[k];
            m_valid[k] = 1'b1;
          end
        end else if (m_hist[k] == COMMA) begin
          m_commas[k]++;
          if (m_commas[k] == m_thresh[k]) m_sync[k] = 1'b1;
        end else begin
          m_found[k]  = 1'b0;
          m_commas[k] = 0;
        end
      end
    end
  endfunction

  always @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      model_clear(0);
      model_clear(1);
    end else begin
      model_step(0, data_in);
      model_step(1, data_in);
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk_32f) begin
    if (!reset) begin
      check("t4 data_out",    data_out4,          m_data[0]);
      check("t4 valid_out",   {7'd0, valid_out4}, {7'd0, m_valid[0]});
      check("t4 active",      {7'd0, active4},    {7'd0, m_sync[0]});
      check("t4 byte_strobe", {7'd0, byte_strobe4}, {7'd0, m_strobe[0]});
      check("t1 data_out",    data_out1,          m_data[1]);
      check("t1 valid_out",   {7'd0, valid_out1}, {7'd0, m_valid[1]});
      check("t1 active",      {7'd0, active1},    {7'd0, m_sync[1]});
      check("t1 byte_strobe", {7'd0, byte_strobe1}, {7'd0, m_strobe[1]});
    end
  end

  // ---------------- stimulus helpers (return 1 time unit after the sampling edge)
  task automatic send_bit(input bit b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    data_in = 1'b0;
    repeat (2) @(posedge clk_32f);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] win;
    bit         b;

    // ---- test 1: four aligned commas from cycle 0
    do_reset();
    check("reset data_out",  data_out4, 8'h00);
    check("reset valid_out", {7'd0, valid_out4}, 8'h00);
    check("reset active",    {7'd0, active4}, 8'h00);
    for (int c = 0; c < 32; c++) begin
      send_bit(COMMA[7 - (c % 8)]);
      check("t1 strobe cycle", {7'd0, byte_strobe4},
            (c == 15 || c == 23 || c == 31) ? 8'h01 : 8'h00);
      check("t1 active cycle", {7'd0, active4}, (c >= 31) ? 8'h01 : 8'h00);
    end
    check("t1 valid stays 0", {7'd0, valid_out4}, 8'h00);
    check("t1 data stays 0",  data_out4, 8'h00);

    // ---- test 2: garbage 101, 4 commas, 0x55, 0xA3, comma
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    repeat (3) send_byte(COMMA);
    check("t2 active before 4th", {7'd0, active4}, 8'h00);
    send_byte(COMMA);
    check("t2 active after 4th",  {7'd0, active4}, 8'h01);
    send_byte(8'h55);
    check("t2 data 55",  data_out4, 8'h55);
    check("t2 valid 55", {7'd0, valid_out4}, 8'h01);
    for (int i = 7; i >= 1; i--) begin
      send_bit(1'(8'hA3 >> i));
      check("t2 data held", data_out4, 8'h55);
    end
    send_bit(1'b1);
    check("t2 data A3",  data_out4, 8'hA3);
    check("t2 valid A3", {7'd0, valid_out4}, 8'h01);
    send_byte(COMMA);
    check("t2 valid drop", {7'd0, valid_out4}, 8'h00);
    check("t2 data kept",  data_out4, 8'hA3);

    // ---- test 3: broken comma run returns to hunt
    do_reset();
    send_byte(COMMA); send_byte(COMMA); send_byte(8'h3C);
    check("t3 no active after break", {7'd0, active4}, 8'h00);
    repeat (3) send_byte(COMMA);
    check("t3 not yet active", {7'd0, active4}, 8'h00);
    send_byte(COMMA);
    check("t3 active after 4 fresh", {7'd0, active4}, 8'h01);

    // ---- test 4: reset mid-byte while active
    send_byte(8'h55);
    check("t4 valid before reset", {7'd0, valid_out4}, 8'h01);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    reset = 1'b1;
    #1;
    check("t4 async data",   data_out4, 8'h00);
    check("t4 async valid",  {7'd0, valid_out4}, 8'h00);
    check("t4 async active", {7'd0, active4}, 8'h00);
    check("t4 async strobe", {7'd0, byte_strobe4}, 8'h00);
    check("t4 async t1 active", {7'd0, active1}, 8'h00);
    repeat (3) @(posedge clk_32f);
    #1;
    reset = 1'b0;
    repeat (3) send_byte(COMMA);
    check("t4 relock not yet", {7'd0, active4}, 8'h00);
    send_byte(COMMA);
    check("t4 relock active", {7'd0, active4}, 8'h01);

    // ---- test 5: threshold of one
    do_reset();
    send_byte(COMMA);
    check("t5 thr1 active",  {7'd0, active1}, 8'h01);
    check("t5 thr4 idle",    {7'd0, active4}, 8'h00);
    send_byte(8'h7E);
    check("t5 thr1 valid",   {7'd0, valid_out1}, 8'h01);
    check("t5 thr1 data",    data_out1, 8'h7E);

    // ---- test 6: random stream with no comma at any offset
    do_reset();
    win = 8'h00;
    for (int c = 0; c < 500; c++) begin
      b = 1'($urandom_range(0, 1));
      if ({win[6:0], b} == COMMA) b = ~b;
      win = {win[6:0], b};
      send_bit(b);
      check("t6 active",  {7'd0, active4 | active1}, 8'h00);
      check("t6 valid",   {7'd0, valid_out4 | valid_out1}, 8'h00);
      check("t6 strobe",  {7'd0, byte_strobe4 | byte_strobe1}, 8'h00);
    end

    @(negedge clk_32f);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
